keccak_padder_param: RTL and testbench

- Parametrised successor to the fixed-rate SHA3 padder feeding the Keccak-f[1600] permutation.
- Accepts IN_W-bit big-endian message words and assembles RATE-bit blocks.
- Applies multi-rate padding with a run-time selectable domain suffix: SHA3 (0x06) or SHAKE (0x1F).
- Covers every Kyber hash instance (SHA3-256/512, SHAKE128/256) from one block; hands each block to the permutation with a ready/ack handshake.

---
 rtl/keccak_padder_param.sv | 194 +++++++++++++++++++
 tb/tb_keccak_padder_param.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_padder_param.sv
// ---------------------------------------------------------------------------
// keccak_padder_param
//
// Purpose:
//   Collects big-endian message words into RATE-bit blocks for the
//   Keccak-f[1600] permutation and applies multi-rate padding with a
//   selectable domain suffix (SHA3 0x06 or SHAKE 0x1F). Each finished block
//   is held on `out` with out_ready high until the permutation returns
//   f_ack. After the padded (last) block is acknowledged the padder stays
//   idle, with buffer_full high, until reset.
//
// Parameters:
//   IN_W  - input word width in bits (32 or 64)
//   RATE  - block width in bits, a multiple of IN_W (576, 1088, 1344)
//   BN_W  - width of byte_num
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-high
//   mode        in   0 = SHA3 suffix 0x06, 1 = SHAKE suffix 0x1F
//   in          in   message word, first byte in the MSBs
//   in_ready    in   word valid
//   is_last     in   final word, carries byte_num valid bytes
//   byte_num    in   valid bytes in the final word (0..IN_W/8-1)
//   buffer_full out  high = input not accepted this cycle
//   out         out  padded block, first message byte in the MSBs
//   out_ready   out  block valid, held until f_ack
//   last_block  out  block contains the padding
//   f_ack       in   permutation has consumed the block
//   msg_bytes   out  message bytes accepted since reset
//                    (only when KECCAK_PAD_BYTECNT_EN is defined)
//
// Build option:
//   KECCAK_PAD_BYTECNT_EN - adds the msg_bytes port and its byte counter.
// ---------------------------------------------------------------------------
module keccak_padder_param #(
    parameter int IN_W = 32,
    parameter int RATE = 1088,
    parameter int BN_W = $clog2(IN_W/8)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mode,
    input  logic [IN_W-1:0] in,
    input  logic            in_ready,
    input  logic            is_last,
    input  logic [BN_W-1:0] byte_num,
    output logic            buffer_full,
    output logic [RATE-1:0] out,
    output logic            out_ready,
    output logic            last_block,
    input  logic            f_ack
`ifdef KECCAK_PAD_BYTECNT_EN
    ,
    output logic [63:0]     msg_bytes
`endif
);

    localparam int WORDS = RATE / IN_W;
    localparam int CNT_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(RATE);
    localparam int BYTES = IN_W / 8;

    typedef enum logic [1:0] {
        S_FILL,
        S_FULL,
        S_LAST,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [RATE-1:0]   r_buf;
    logic              r_out_ready;
    logic              r_last_block;
    logic              r_full;

    logic [7:0]        w_suffix;
    logic [IN_W-1:0]   w_pad_word;
    logic [IDX_W-1:0]  w_base;
    logic [RATE-1:0]   w_buf_next;
    logic              w_accept;
    logic              w_cnt_last;

    assign w_suffix   = mode ? 8'h1F : 8'h06;
    assign w_accept   = (r_state == S_FILL) && in_ready && !r_full;
    assign w_cnt_last = (r_cnt == CNT_W'(WORDS - 1));

    // Final word: keep the first byte_num bytes, put the domain suffix right
    // after them and zero everything further down the word.
    always_comb begin
        w_pad_word = '0;
        for (int j = 0; j < BYTES; j++) begin
            if (j < int'(byte_num)) begin
                w_pad_word[IN_W-1-8*j -: 8] = in[IN_W-1-8*j -: 8];
            end else if (j == int'(byte_num)) begin
                w_pad_word[IN_W-1-8*j -: 8] = w_suffix;
            end
        end
    end

    // Slot 0 sits in the MSBs of the block, so slot cnt starts at bit
    // (WORDS-1-cnt)*IN_W. The closing 0x80 is ORed into the last block byte
    // so it merges with the suffix when both land on the same byte; the
    // remainder of the buffer is already zero from the block start.
    always_comb begin
        w_base     = IDX_W'((WORDS - 1 - int'(r_cnt)) * IN_W);
        w_buf_next = r_buf;
        if (is_last) begin
            w_buf_next[w_base +: IN_W] = w_pad_word;
            w_buf_next[7:0]            = w_buf_next[7:0] | 8'h80;
        end else begin
            w_buf_next[w_base +: IN_W] = in;
        end
    end

    // Block FSM. Filling stops as soon as a block is complete; buffer_full
    // stays high until the permutation acknowledges it, so the buffer (and
    // therefore out) cannot change while out_ready is high. f_ack is only
    // looked at in the two states where out_ready is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_FILL;
            r_cnt        <= '0;
            r_buf        <= '0;
            r_out_ready  <= 1'b0;
            r_last_block <= 1'b0;
            r_full       <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        r_buf <= w_buf_next;
                        if (is_last) begin
                            r_state      <= S_LAST;
                            r_out_ready  <= 1'b1;
                            r_last_block <= 1'b1;
                            r_full       <= 1'b1;
                        end else if (w_cnt_last) begin
                            r_state     <= S_FULL;
                            r_out_ready <= 1'b1;
                            r_full      <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_FULL: begin
                    if (f_ack) begin
                        r_state     <= S_FILL;
                        r_out_ready <= 1'b0;
                        r_buf       <= '0;
                        r_cnt       <= '0;
                        r_full      <= 1'b0;
                    end
                end
                S_LAST: begin
                    if (f_ack) begin
                        r_state      <= S_DONE;
                        r_out_ready  <= 1'b0;
                        r_last_block <= 1'b0;
                    end
                end
                default: begin
                    r_full <= 1'b1;
                end
            endcase
        end
    end

    assign out         = r_buf;
    assign out_ready   = r_out_ready;
    assign last_block  = r_last_block;
    assign buffer_full = r_full;

`ifdef KECCAK_PAD_BYTECNT_EN
    logic [63:0] r_msg_bytes;

    // Byte counter only moves on accepted words, which can only happen in
    // FILL, so it freezes naturally once the padder reaches DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_msg_bytes <= '0;
        end else if (w_accept) begin
            r_msg_bytes <= r_msg_bytes + (is_last ? 64'(byte_num) : 64'(BYTES));
        end
    end

    assign msg_bytes = r_msg_bytes;
`else
    // Without the byte counter the padder exposes only the block interface.
`endif

endmodule

// File: tb/tb_keccak_padder_param.sv
// ---------------------------------------------------------------------------
// tb_keccak_padder_param
//
// Purpose:
//   Directed bench for keccak_padder_param. Three instances (RATE 1088, 1344
//   and 576, IN_W 32) share one set of inputs; every scenario resets all of
//   them and then checks the instance whose rate it targets against
//   hand-computed blocks.
// ---------------------------------------------------------------------------
module tb_keccak_padder_param;

    logic         clk = 1'b0;
    logic         reset;
    logic         mode;
    logic [31:0]  inWord;
    logic         inReady;
    logic         isLast;
    logic [1:0]   byteNum;
    logic         fAck;

    logic [1087:0] outA;
    logic [1343:0] outB;
    logic [575:0]  outC;
    logic          outReadyA, outReadyB, outReadyC;
    logic          lastBlockA, lastBlockB, lastBlockC;
    logic          bufferFullA, bufferFullB, bufferFullC;
`ifdef KECCAK_PAD_BYTECNT_EN
    logic [63:0]   msgBytesA, msgBytesB, msgBytesC;
`endif

    int checkCount = 0;
    int errorCount = 0;

    logic [1343:0] expBlk;
    logic [1343:0] emptyBlkA;
    logic [1343:0] blkA, blkB, blkC;

    assign blkA = {256'b0, outA};
    assign blkB = outB;
    assign blkC = {768'b0, outC};

    // 100 MHz style free-running clock
    always #5 clk = ~clk;

    keccak_padder_param #(.IN_W(32), .RATE(1088)) dutA (
        .clk(clk), .reset(reset), .mode(mode), .in(inWord), .in_ready(inReady),
        .is_last(isLast), .byte_num(byteNum), .buffer_full(bufferFullA),
        .out(outA), .out_ready(outReadyA), .last_block(lastBlockA), .f_ack(fAck)
`ifdef KECCAK_PAD_BYTECNT_EN
        , .msg_bytes(msgBytesA)
`endif
    );

    keccak_padder_param #(.IN_W(32), .RATE(1344)) dutB (
        .clk(clk), .reset(reset), .mode(mode), .in(inWord), .in_ready(inReady),
        .is_last(isLast), .byte_num(byteNum), .buffer_full(bufferFullB),
        .out(outB), .out_ready(outReadyB), .last_block(lastBlockB), .f_ack(fAck)
`ifdef KECCAK_PAD_BYTECNT_EN
        , .msg_bytes(msgBytesB)
`endif
    );

    keccak_padder_param #(.IN_W(32), .RATE(576)) dutC (
        .clk(clk), .reset(reset), .mode(mode), .in(inWord), .in_ready(inReady),
        .is_last(isLast), .byte_num(byteNum), .buffer_full(bufferFullC),
        .out(outC), .out_ready(outReadyC), .last_block(lastBlockC), .f_ack(fAck)
`ifdef KECCAK_PAD_BYTECNT_EN
        , .msg_bytes(msgBytesC)
`endif
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Whole-block compare: picks the first differing 64-bit chunk (or chunk 0
    // when they agree) and hands that chunk to checkOutput
    task automatic checkBlock(input string tag, input logic [1343:0] observed,
                              input logic [1343:0] expected);
        int k;
        k = 0;
        for (int i = 20; i >= 0; i--) begin
            if (observed[i*64 +: 64] !== expected[i*64 +: 64]) k = i;
        end
        checkOutput($sformatf("%s.chunk%0d", tag, k), observed[k*64 +: 64],
                    expected[k*64 +: 64]);
    endtask

    // Drives one word for exactly one rising edge, from one falling edge to the next
    task automatic applyStimulus(input logic [31:0] word, input logic last,
                                 input logic [1:0] bnum);
        inWord  = word;
        inReady = 1'b1;
        isLast  = last;
        byteNum = bnum;
        @(negedge clk);
        inWord  = '0;
        inReady = 1'b0;
        isLast  = 1'b0;
        byteNum = '0;
    endtask

    task automatic pulseAck();
        fAck = 1'b1;
        @(negedge clk);
        fAck = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Safety net in case the stimulus ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset   = 1'b1;
        mode    = 1'b0;
        inWord  = '0;
        inReady = 1'b0;
        isLast  = 1'b0;
        byteNum = '0;
        fAck    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        checkOutput("rst.outReady", outReadyA, 0);
        checkOutput("rst.lastBlock", lastBlockA, 0);
        checkOutput("rst.bufferFull", bufferFullA, 0);
        checkBlock("rst.out", blkA, '0);
`ifdef KECCAK_PAD_BYTECNT_EN
        checkOutput("rst.msgBytes", msgBytesA, 0);
`endif

        // Empty SHA3 message, RATE 1088
        emptyBlkA = '0;
        emptyBlkA[1087:1080] = 8'h06;
        emptyBlkA[7:0] = 8'h80;
        mode = 1'b0;
        applyStimulus(32'h0, 1'b1, 2'd0);
        checkOutput("empty.outReady", outReadyA, 1);
        checkOutput("empty.lastBlock", lastBlockA, 1);
        checkOutput("empty.bufferFull", bufferFullA, 1);
        checkBlock("empty.out", blkA, emptyBlkA);
        pulseAck();
        checkOutput("empty.ackOutReady", outReadyA, 0);
        checkOutput("empty.ackLastBlock", lastBlockA, 0);
        checkOutput("empty.doneFull", bufferFullA, 1);

        // SHAKE, RATE 1344, five-byte message
        doReset();
        mode = 1'b1;
        applyStimulus(32'hA1A2A3A4, 1'b0, 2'd0);
        checkOutput("shake.midOutReady", outReadyB, 0);
        applyStimulus(32'hA5000000, 1'b1, 2'd1);
        expBlk = '0;
        expBlk[1343:1296] = 48'hA1A2A3A4A51F;
        expBlk[7:0] = 8'h80;
        checkOutput("shake.outReady", outReadyB, 1);
        checkOutput("shake.lastBlock", lastBlockB, 1);
        checkBlock("shake.out", blkB, expBlk);
`ifdef KECCAK_PAD_BYTECNT_EN
        checkOutput("shake.msgBytes", msgBytesB, 64'd5);
`endif
        mode = 1'b0;

        // Suffix lands on the final byte, RATE 576
        doReset();
        for (int k = 0; k < 17; k++) applyStimulus(32'hEFCDAB90, 1'b0, 2'd0);
        applyStimulus(32'h78563412, 1'b1, 2'd3);
        expBlk = '0;
        for (int k = 0; k < 17; k++) expBlk[575-32*k -: 32] = 32'hEFCDAB90;
        expBlk[31:0] = 32'h78563486;
        checkOutput("sufx.tail", outC[31:0], 32'h78563486);
        checkOutput("sufx.lastBlock", lastBlockC, 1);
        checkBlock("sufx.out", blkC, expBlk);
`ifdef KECCAK_PAD_BYTECNT_EN
        checkOutput("sufx.msgBytes", msgBytesC, 64'd71);
`endif

        // Backpressure: no ack for 5 cycles, block must hold
        for (int k = 0; k < 5; k++) @(negedge clk);
        checkBlock("bp.out", blkC, expBlk);
        checkOutput("bp.outReady", outReadyC, 1);
        checkOutput("bp.bufferFull", bufferFullC, 1);
        pulseAck();
        checkOutput("bp.ackOutReady", outReadyC, 0);

        // DONE ignores further final words
        for (int k = 0; k < 5; k++) begin
            inReady = 1'b1;
            isLast  = 1'b1;
            byteNum = 2'd1;
            inWord  = 32'h12345678;
            @(negedge clk);
            checkOutput($sformatf("done.outReady%0d", k), outReadyC, 0);
            checkOutput($sformatf("done.bufferFull%0d", k), bufferFullC, 1);
        end
        inReady = 1'b0;
        isLast  = 1'b0;
        byteNum = '0;
        inWord  = '0;
`ifdef KECCAK_PAD_BYTECNT_EN
        checkOutput("done.msgBytes", msgBytesC, 64'd71);
`endif

        // Exact block, RATE 576: 18 full words then a separate padding block
        doReset();
        expBlk = '0;
        for (int k = 0; k < 18; k++) begin
            applyStimulus(32'h11000000 + 32'(k), 1'b0, 2'd0);
            expBlk[575-32*k -: 32] = 32'h11000000 + 32'(k);
        end
        checkOutput("exact.outReady", outReadyC, 1);
        checkOutput("exact.lastBlock", lastBlockC, 0);
        checkOutput("exact.bufferFull", bufferFullC, 1);
        checkBlock("exact.out", blkC, expBlk);
        applyStimulus(32'hDEADBEEF, 1'b0, 2'd0);
        applyStimulus(32'hCAFEF00D, 1'b1, 2'd2);
        checkBlock("exact.ignored", blkC, expBlk);
        checkOutput("exact.ignoredLast", lastBlockC, 0);
        pulseAck();
        checkOutput("exact.ackOutReady", outReadyC, 0);
        checkOutput("exact.ackBufferFull", bufferFullC, 0);
        checkBlock("exact.cleared", blkC, '0);
        applyStimulus(32'h0, 1'b1, 2'd0);
        expBlk = '0;
        expBlk[575:568] = 8'h06;
        expBlk[7:0] = 8'h80;
        checkOutput("exact2.outReady", outReadyC, 1);
        checkOutput("exact2.lastBlock", lastBlockC, 1);
        checkBlock("exact2.out", blkC, expBlk);
`ifdef KECCAK_PAD_BYTECNT_EN
        checkOutput("exact2.msgBytes", msgBytesC, 64'd72);
`endif

        // Reset mid-fill discards the partial block; reset also beats is_last
        doReset();
        for (int k = 0; k < 3; k++) applyStimulus(32'h55AA55AA, 1'b0, 2'd0);
        reset = 1'b1;
        applyStimulus(32'h0, 1'b1, 2'd0);
        reset = 1'b0;
        checkOutput("midrst.outReady", outReadyA, 0);
        checkOutput("midrst.bufferFull", bufferFullA, 0);
        checkBlock("midrst.cleared", blkA, '0);
        applyStimulus(32'h0, 1'b1, 2'd0);
        checkOutput("midrst.emptyReady", outReadyA, 1);
        checkBlock("midrst.out", blkA, emptyBlkA);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
